// File: rtl/countup_stopwatch.sv
// Up-counting M:SS stopwatch with BCD digit outputs and run/done status.
// Optional LAP_HOLD_EN adds a lap input that freezes the displayed digits.
module countup_stopwatch #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic [1:0] limit_minutes,
`ifdef LAP_HOLD_EN
    input  logic       lap,
`endif
    output logic [3:0] seconds_digit,
    output logic [3:0] tens_digit,
    output logic [1:0] minutes_digit,
    output logic       running,
    output logic       done,
    output logic       tick
);

    localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DivLoad = DW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e        state_q, state_d;
    logic [3:0]    sec_q, sec_d, ten_q, ten_d;
    logic [1:0]    min_q, min_d, lim_q, lim_d;
    logic [DW-1:0] div_q, div_d;
    logic          tick_d;

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        ten_d   = ten_q;
        min_d   = min_q;
        lim_d   = lim_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        if (clear) begin
            state_d = StIdle;
            sec_d   = 4'd0;
            ten_d   = 4'd0;
            min_d   = 2'd0;
            div_d   = DivLoad;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start && !stop) begin
                        state_d = StRun;
                        lim_d   = limit_minutes;
                        div_d   = DivLoad;
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_d = StPause;
                    end else if (div_q == '0) begin
                        div_d  = DivLoad;
                        tick_d = 1'b1;
                        if (sec_q == 4'd9) begin
                            sec_d = 4'd0;
                            if (ten_q == 4'd5) begin
                                ten_d = 4'd0;
                                min_d = min_q + 2'd1;
                            end else begin
                                ten_d = ten_q + 4'd1;
                            end
                        end else begin
                            sec_d = sec_q + 4'd1;
                        end
                        // Halt exactly on lim:00; lim 0 means free-run with 3:59 -> 0:00 wrap.
                        if (lim_q != 2'd0 && min_d == lim_q && ten_d == 4'd0 && sec_d == 4'd0) begin
                            state_d = StDone;
                        end
                    end else begin
                        div_d = div_q - 1'b1;
                    end
                end
                StPause: begin
                    if (start && !stop) state_d = StRun;
                end
                StDone:  ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            sec_q   <= 4'd0;
            ten_q   <= 4'd0;
            min_q   <= 2'd0;
            lim_q   <= 2'd0;
            div_q   <= DivLoad;
            tick    <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            ten_q   <= ten_d;
            min_q   <= min_d;
            lim_q   <= lim_d;
            div_q   <= div_d;
            tick    <= tick_d;
            running <= (state_d == StRun);
            done    <= (state_d == StDone);
        end
    end

`ifdef LAP_HOLD_EN
    logic       lap_q, hold;
    logic [3:0] sec_disp_q, ten_disp_q;
    logic [1:0] min_disp_q;

    // The edge where lap is first seen loads the live count; later lap-high edges keep it.
    assign hold = lap && lap_q && (state_d == StRun || state_d == StPause);

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            lap_q      <= 1'b0;
            sec_disp_q <= 4'd0;
            ten_disp_q <= 4'd0;
            min_disp_q <= 2'd0;
        end else begin
            lap_q <= lap;
            if (!hold) begin
                sec_disp_q <= sec_d;
                ten_disp_q <= ten_d;
                min_disp_q <= min_d;
            end
        end
    end

    assign seconds_digit = sec_disp_q;
    assign tens_digit    = ten_disp_q;
    assign minutes_digit = min_disp_q;
`else
    assign seconds_digit = sec_q;
    assign tens_digit    = ten_q;
    assign minutes_digit = min_q;
`endif

endmodule
